mainfsm: RTL and testbench
==========================

# mainfsm

Multicycle control unit that sequences each instruction through fetch, decode, execute, memory and writeback states. It decodes Op/Funct/Rd from the instruction register. It drives the datapath mux selects and the unconditioned write requests (PCS, RegW, MemW, FlagW) consumed by the condition-logic stage, which gates them with CondEx. A memory-ready handshake stretches memory-access states.

## Interface
Parameters: none.
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low (0 = reset)
- Op  input  2  instr[27:26]; stable from DECODE until return to FETCH
- Funct  input  6  instr[25:20]
- Rd  input  4  instr[15:12]
- MemReady  input  1  memory completes current access this cycle
- IRWrite  output  1  load instruction register
- NextPC  output  1  unconditional PC write
- PCS  output  1  conditional PC write request
- RegW  output  1  register-file write request
- MemW  output  1  memory write request
- FlagW  output  2  [1]=NZ, [0]=CV flag write request
- AdrSrc  output  1  0=PC, 1=ALU result register
- ALUSrcA  output  1  0=RD1, 1=PC
- ALUSrcB  output  2  00=RD2, 01=ExtImm, 10=const 4
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult, 11=PC
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- LinkSel  output  1  force write address R14
- Undef  output  1  one-cycle pulse, undefined instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH (+BLLINK, see Configuration). Moore outputs; unlisted signals are 0.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=MemReady. Stay while MemReady=0; else go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Op=00 goes to EXECUTEI if Funct[5], else EXECUTER. Op=01 goes to MEMADR. Op=10 goes to BRANCH. Op=11 pulses Undef and goes to FETCH.
- MEMADR: ALUSrcB=01. Goes to MEMRD if Funct[0] (load), else MEMWR.
- MEMRD: AdrSrc=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegW=1, then FETCH.
- MEMWR: AdrSrc=1, MemW=1 every cycle in state. Holds until MemReady, then FETCH.
- EXECUTER: ALUSrcB=00, ALU decode active, then ALUWB.
- EXECUTEI: ALUSrcB=01, ALU decode active, then ALUWB.
- ALUWB: ResultSrc=00, RegW=~NoWrite, then FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1, then FETCH.
- PCS = Branch | (RegW & Rd==4'hF). Computed combinationally from the state's outputs.
- ALU decode (EXECUTER/EXECUTEI/ALUWB only; elsewhere ALUControl=00, FlagW=00), cmd=Funct[4:1]:
  - 0100 gives ADD.
  - 0010 gives SUB.
  - 0000 gives AND.
  - 1100 gives ORR.
  - 1010 (CMP) gives SUB with NoWrite=1.
  - Any other cmd gives ADD, with Undef pulsed in EXECUTER/EXECUTEI.
- FlagW[1]=Funct[0]. FlagW[0]=Funct[0] & cmd∈{ADD,SUB,CMP}. FlagW is asserted in EXECUTE* only, so flags update once.

## Timing
- Latency in cycles, with MemReady=1: LDR 5, STR 4, data-processing 4, branch 3, undefined 2.
- Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Reset asserted: state=FETCH asynchronously. IRWrite, NextPC, PCS, RegW, MemW, FlagW, Undef and LinkSel are forced 0. Selects show FETCH values.
- First fetch occurs on the first edge after reset deasserts.
- Reset mid-instruction abandons it; no partial write is issued after reset asserts.
- MemReady is ignored outside FETCH/MEMRD/MEMWR.

## Configuration
- MAINFSM_BL_EN defined:
  - Op=10 with Funct[4]=1 goes DECODE→BLLINK→BRANCH.
  - BLLINK: RegW=1, LinkSel=1, ResultSrc=11; PCS=0 (LinkSel overrides Rd).
  - BL latency is 4.
- Undefined: the BLLINK state is absent, LinkSel is tied 0, and BL executes as a plain branch.

## Test plan
- Reset low mid-EXECUTER, then released → all enables 0 during reset; first cycle after release: IRWrite=1, NextPC=1.
- ADDS R1 (Op=00, Funct=6'b001001, Rd=1), MemReady=1 → FETCH,DECODE,EXECUTEI,ALUWB. ALUControl=00 and FlagW=11 in EXECUTEI. RegW=1 and PCS=0 in ALUWB.
- CMP (Funct=6'b010101) → ALUControl=01, FlagW=11, no RegW in ALUWB.
- LDR to R15 with MemReady low for 2 cycles in MEMRD → MEMRD held 3 cycles. MEMWB gives RegW=1, PCS=1. Total 7 cycles.
- STR with MemReady=0 for 1 cycle → MemW=1 for 2 consecutive cycles, then FETCH.
- Op=11 → Undef=1 for exactly one DECODE cycle, no writes. BL with MAINFSM_BL_EN gives LinkSel=1, RegW=1, then Branch, PCS=1.

Source files
------------

// File: rtl/mainfsm.sv
// ============================================================================
// mainfsm : multicycle control unit (fetch/decode/execute/memory/writeback).
// Defining MAINFSM_BL_EN adds the BLLINK state for branch-with-link.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       LinkSel,
    output logic       Undef
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
`ifdef MAINFSM_BL_EN
        ,
        S_BLLINK   = 4'd10
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_irw;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_link;
    logic       w_undef;
    logic       w_alu_en;
    logic       w_flag_en;
    logic [1:0] w_alu_ctl;
    logic       w_nowrite;
    logic       w_cmd_undef;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ALU command decode; only exposed in the execute/writeback states
    always_comb begin
        w_alu_ctl   = 2'b00;
        w_nowrite   = 1'b0;
        w_cmd_undef = 1'b0;
        case (Funct[4:1])
            4'b0100: w_alu_ctl = 2'b00;
            4'b0010: w_alu_ctl = 2'b01;
            4'b0000: w_alu_ctl = 2'b10;
            4'b1100: w_alu_ctl = 2'b11;
            4'b1010: begin
                w_alu_ctl = 2'b01;
                w_nowrite = 1'b1;
            end
            default: w_cmd_undef = 1'b1;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_irw     = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_branch  = 1'b0;
        w_link    = 1'b0;
        w_undef   = 1'b0;
        w_alu_en  = 1'b0;
        w_flag_en = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irw     = MemReady;
                w_next    = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
`ifdef MAINFSM_BL_EN
                    2'b10:   w_next = Funct[4] ? S_BLLINK : S_BRANCH;
`else
                    2'b10:   w_next = S_BRANCH;
`endif
                    default: begin
                        w_undef = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
                w_next = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECUTER: begin
                ALUSrcB   = 2'b00;
                w_alu_en  = 1'b1;
                w_flag_en = 1'b1;
                w_undef   = w_cmd_undef;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB   = 2'b01;
                w_alu_en  = 1'b1;
                w_flag_en = 1'b1;
                w_undef   = w_cmd_undef;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                w_alu_en  = 1'b1;
                w_regw    = ~w_nowrite;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
                w_next    = S_FETCH;
            end
`ifdef MAINFSM_BL_EN
            S_BLLINK: begin
                ResultSrc = 2'b11;
                w_regw    = 1'b1;
                w_link    = 1'b1;
                w_next    = S_BRANCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // Every write enable is masked while reset is low so an abandoned
    // instruction cannot leak a write in the reset cycle itself.
    assign IRWrite    = reset & w_irw;
    assign NextPC     = reset & w_irw;
    assign RegW       = reset & w_regw;
    assign MemW       = reset & w_memw;
    assign LinkSel    = reset & w_link;
    assign Undef      = reset & w_undef;
    assign PCS        = reset & (w_branch | (w_regw & (Rd == 4'hF) & ~w_link));
    assign ALUControl = w_alu_en ? w_alu_ctl : 2'b00;
    assign FlagW      = (reset & w_flag_en) ? {Funct[0], Funct[0] & ~w_alu_ctl[1]} : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: an instruction-level model pushes the expected
// per-cycle control vector; a negedge monitor pops and compares.
`default_nettype none

module tb_mainfsm;

    typedef struct packed {
        logic       irw;
        logic       npc;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       adrsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] ressrc;
        logic [1:0] aluctl;
        logic       link;
        logic       undef;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'b0;
    logic       MemReady = 1'b1;
    logic       IRWrite, NextPC, PCS, RegW, MemW, AdrSrc, ALUSrcA, LinkSel, Undef;
    logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl;

    mainfsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .FlagW(FlagW), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .LinkSel(LinkSel), .Undef(Undef)
    );

    always #5 clk = ~clk;

    out_t act;
    assign act = {IRWrite, NextPC, PCS, RegW, MemW, FlagW, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ALUControl, LinkSel, Undef};

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    out_t exp_q[$];
    int   cyc = 0;

    task automatic chk(input string name, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction-level reference: the control vector of each step of an instruction
    function automatic out_t fetch_v(input logic mr);
        out_t v = '0;
        v.srca = 1'b1; v.srcb = 2'b10; v.ressrc = 2'b10;
        v.irw = mr; v.npc = mr;
        return v;
    endfunction

    function automatic void alu_ref(input logic [3:0] cmd, output logic [1:0] ctl,
                                    output logic nowr, output logic known);
        nowr = 1'b0; known = 1'b1;
        case (cmd)
            4'b0100: ctl = 2'b00;
            4'b0010: ctl = 2'b01;
            4'b0000: ctl = 2'b10;
            4'b1100: ctl = 2'b11;
            4'b1010: begin ctl = 2'b01; nowr = 1'b1; end
            default: begin ctl = 2'b00; known = 1'b0; end
        endcase
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got %h expected nothing", act);
            end else begin
                out_t e;
                e = exp_q.pop_front();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL cycle%0d op=%0d funct=%b rd=%0d: got %h expected %h",
                             cyc, Op, Funct, Rd, act, e);
                end
            end
        end
    end

    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input int fw, input int mw);
        out_t       v;
        logic       mq[$];
        logic [1:0] ctl;
        logic       nowr, known;
        for (int i = 0; i <= fw; i++) begin
            exp_q.push_back(fetch_v(i == fw));
            mq.push_back(i == fw);
        end
        v = fetch_v(1'b0);
        v.undef = (op == 2'b11);
        exp_q.push_back(v);
        mq.push_back(1'($urandom_range(0, 1)));
        case (op)
            2'b00: begin
                alu_ref(funct[4:1], ctl, nowr, known);
                v = '0;
                v.srcb   = funct[5] ? 2'b01 : 2'b00;
                v.aluctl = ctl;
                v.flagw  = {funct[0], funct[0] & (ctl == 2'b00 || ctl == 2'b01)};
                v.undef  = ~known;
                exp_q.push_back(v);
                mq.push_back(1'($urandom_range(0, 1)));
                v = '0;
                v.aluctl = ctl;
                v.regw   = ~nowr;
                v.pcs    = ~nowr & (rd == 4'hF);
                exp_q.push_back(v);
                mq.push_back(1'($urandom_range(0, 1)));
            end
            2'b01: begin
                v = '0;
                v.srcb = 2'b01;
                exp_q.push_back(v);
                mq.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i <= mw; i++) begin
                    v = '0;
                    v.adrsrc = 1'b1;
                    v.memw   = ~funct[0];
                    exp_q.push_back(v);
                    mq.push_back(i == mw);
                end
                if (funct[0]) begin
                    v = '0;
                    v.ressrc = 2'b01;
                    v.regw   = 1'b1;
                    v.pcs    = (rd == 4'hF);
                    exp_q.push_back(v);
                    mq.push_back(1'($urandom_range(0, 1)));
                end
            end
            2'b10: begin
`ifdef MAINFSM_BL_EN
                if (funct[4]) begin
                    v = '0;
                    v.regw = 1'b1; v.link = 1'b1; v.ressrc = 2'b11;
                    exp_q.push_back(v);
                    mq.push_back(1'($urandom_range(0, 1)));
                end
`endif
                v = '0;
                v.srcb = 2'b01; v.ressrc = 2'b10; v.pcs = 1'b1;
                exp_q.push_back(v);
                mq.push_back(1'($urandom_range(0, 1)));
            end
            default: ;
        endcase
        Op = op; Funct = funct; Rd = rd;
        foreach (mq[k]) begin
            MemReady = mq[k];
            @(posedge clk);
            #1;
        end
    endtask

    out_t rst_v;
    out_t ex_v;

    initial begin
        rst_v = fetch_v(1'b0);
        // Reset held: FETCH selects, every enable low even with MemReady high
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", rst_v);
        reset = 1'b1;
        #1;
        chk("release_fetch", fetch_v(1'b1));
        Op = 2'b00; Funct = 6'b000101; Rd = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ex_v = '0;
        ex_v.aluctl = 2'b01; ex_v.flagw = 2'b11;
        chk("mid_executer", ex_v);
        #3 reset = 1'b0;
        #1;
        chk("reset_mid_instr", rst_v);
        @(posedge clk); #1;
        chk("reset_no_partial_write", rst_v);

        mon_en = 1'b1;
        reset  = 1'b1;
        run_instr(2'b00, 6'b001001, 4'd1, 0, 0);   // ADDS R1, imm
        run_instr(2'b00, 6'b010101, 4'd3, 0, 0);   // CMP
        run_instr(2'b01, 6'b000001, 4'hF, 0, 2);   // LDR R15, two wait cycles
        run_instr(2'b01, 6'b000000, 4'd2, 0, 1);   // STR, one wait cycle
        run_instr(2'b11, 6'b000000, 4'd0, 0, 0);   // undefined
        run_instr(2'b10, 6'b010000, 4'd0, 0, 0);   // BL
        run_instr(2'b10, 6'b000000, 4'd0, 1, 0);   // B after fetch stall
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            logic [5:0] fn;
            logic [3:0] rd;
            logic [1:0] c;
            logic       nw, kn;
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            alu_ref(fn[4:1], c, nw, kn);
            if (op == 2'b00 && !kn) fn[0] = 1'b0;
            run_instr(op, fn, rd, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        mon_en = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
